// File: rtl/store_buffer_if.sv
// Core/memory-side bundle of the posted-write store buffer.
interface store_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          MemWrite;
  logic [AW-1:0] ALUResult;
  logic [DW-1:0] WriteData;
  logic          Stall;
  logic          FwdHit;
  logic [DW-1:0] FwdData;
  logic          MemValid;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic          MemReady;
  logic          Empty;
  logic [CW-1:0] Count;

  // Core and memory together drive the requests and the ready
  modport master (
    output MemWrite, ALUResult, WriteData, MemReady,
    input  Stall, FwdHit, FwdData, MemValid, MemAddr, MemWData, Empty, Count
  );

  // The buffer itself
  modport slave (
    input  MemWrite, ALUResult, WriteData, MemReady,
    output Stall, FwdHit, FwdData, MemValid, MemAddr, MemWData, Empty, Count
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core data port and data memory, with
// youngest-match store-to-load forwarding on word addresses.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic          full, empty, push, pop;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] fwd_idx;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // No pass-through: a full buffer refuses the push even when popping
  assign push  = bus.MemWrite && !full;
  assign pop   = !empty && bus.MemReady;

  // Next pointers and occupancy
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: write at tail on push, invalidate head on pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[wr_ptr_q]  <= bus.ALUResult;
        data_q[wr_ptr_q]  <= bus.WriteData;
        valid_q[wr_ptr_q] <= 1'b1;
      end
      if (pop) valid_q[rd_ptr_q] <= 1'b0;
    end
  end

  // Forwarding: walk back from the youngest entry (wr_ptr-1), first valid
  // word-address match wins; register state only, so this cycle's push is
  // invisible and this cycle's pop still forwards.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = wr_ptr_q - PW'(i + 1);
      if (!fwd_hit && valid_q[fwd_idx] &&
          (addr_q[fwd_idx][AW-1:2] == bus.ALUResult[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign bus.Stall    = bus.MemWrite && full;
  assign bus.FwdHit   = fwd_hit;
  assign bus.FwdData  = fwd_data;
  assign bus.MemValid = !empty;
  assign bus.MemAddr  = addr_q[rd_ptr_q];
  assign bus.MemWData = data_q[rd_ptr_q];
  assign bus.Empty    = empty;
  assign bus.Count    = count_q;
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  logic clk;
  logic reset;

  store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  entry_t        model_q[$];
  logic [AW-1:0] drained[$];

  logic          obs_stall, obs_hit, obs_valid, obs_empty;
  logic [DW-1:0] obs_fdata, obs_wdata;
  logic [AW-1:0] obs_addr;
  logic [31:0]   obs_count;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Youngest buffered store to the same word address
  task automatic model_fwd(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (!hit && (model_q[i].addr[AW-1:2] == a[AW-1:2])) begin
        hit = 1'b1;
        d   = model_q[i].data;
      end
    end
  endtask

  // One clock: drive at negedge, compare combinational outputs, then let the
  // edge happen and advance the reference queue.
  task automatic step(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rdy);
    logic          e_hit;
    logic [DW-1:0] e_data;
    bit            m_push, m_pop;
    @(negedge clk);
    bus.MemWrite  = we;
    bus.ALUResult = a;
    bus.WriteData = d;
    bus.MemReady  = rdy;
    #1;
    obs_stall = bus.Stall;
    obs_hit   = bus.FwdHit;
    obs_fdata = bus.FwdData;
    obs_valid = bus.MemValid;
    obs_addr  = bus.MemAddr;
    obs_wdata = bus.MemWData;
    obs_empty = bus.Empty;
    obs_count = 32'(bus.Count);
    model_fwd(a, e_hit, e_data);
    check("stall",   64'(obs_stall), 64'(we && (model_q.size() == DEPTH)));
    check("fwdhit",  64'(obs_hit),   64'(e_hit));
    check("fwddata", 64'(obs_fdata), 64'(e_data));
    check("memvalid",64'(obs_valid), 64'(model_q.size() != 0));
    check("empty",   64'(obs_empty), 64'(model_q.size() == 0));
    check("count",   64'(obs_count), 64'(model_q.size()));
    if (model_q.size() != 0) begin
      check("memaddr",  64'(obs_addr),  64'(model_q[0].addr));
      check("memwdata", 64'(obs_wdata), 64'(model_q[0].data));
    end
    m_pop  = (model_q.size() != 0) && rdy;
    m_push = we && (model_q.size() < DEPTH);
    @(posedge clk);
    if (m_pop) begin
      drained.push_back(model_q[0].addr);
      void'(model_q.pop_front());
    end
    if (m_push) model_q.push_back('{addr: a, data: d});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b0;
    bus.MemWrite  = 1'b1;
    bus.ALUResult = 32'h64;
    bus.WriteData = 32'h5;
    bus.MemReady  = 1'b1;
    model_q.delete();
    drained.delete();
    #1;
    check("rst_memvalid", 64'(bus.MemValid), 64'd0);
    check("rst_memaddr",  64'(bus.MemAddr),  64'd0);
    check("rst_memwdata", 64'(bus.MemWData), 64'd0);
    check("rst_empty",    64'(bus.Empty),    64'd1);
    check("rst_count",    64'(bus.Count),    64'd0);
    check("rst_fwdhit",   64'(bus.FwdHit),   64'd0);
    check("rst_fwddata",  64'(bus.FwdData),  64'd0);
    check("rst_stall",    64'(bus.Stall),    64'd0);
    @(negedge clk);
    bus.MemWrite = 1'b0;
    bus.MemReady = 1'b0;
    reset        = 1'b1;
  endtask

  task automatic single_store();
    step(1'b1, 32'h64, 32'd7, 1'b0);
    step(1'b0, 32'h0, 32'd0, 1'b0);
    check("s1_valid", 64'(obs_valid), 64'd1);
    check("s1_addr",  64'(obs_addr),  64'h64);
    check("s1_data",  64'(obs_wdata), 64'd7);
    check("s1_count", 64'(obs_count), 64'd1);
    step(1'b0, 32'h0, 32'd0, 1'b1);
    step(1'b0, 32'h0, 32'd0, 1'b0);
    check("s1_empty", 64'(obs_empty), 64'd1);
  endtask

  initial begin
    int unsigned tries;
    logic [AW-1:0] a;
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.ALUResult = '0;
    bus.WriteData = '0;
    bus.MemReady  = 1'b0;
    #2;
    do_reset();

    single_store();

    // Fill, stall, refused push on full+pop, then in-order drain
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h60 + 32'(4 * i), 32'(i + 1), 1'b0);
      check("fill_stall", 64'(obs_stall), 64'd0);
    end
    step(1'b1, 32'h70, 32'd5, 1'b0);
    check("full_stall", 64'(obs_stall), 64'd1);
    check("full_count", 64'(obs_count), 64'd4);
    step(1'b1, 32'h70, 32'd5, 1'b1);
    check("pp_stall", 64'(obs_stall), 64'd1);
    step(1'b1, 32'h70, 32'd5, 1'b0);
    check("after_pop_stall", 64'(obs_stall), 64'd0);
    check("after_pop_count", 64'(obs_count), 64'd3);
    drained.delete();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'd0, 1'b1);
    check("drain_n", 64'(drained.size()), 64'd4);
    for (int i = 0; i < 4 && i < drained.size(); i++)
      check("drain_order", 64'(drained[i]), 64'(32'h64 + 32'(4 * i)));

    // Forwarding priority
    step(1'b1, 32'h64, 32'd3, 1'b0);
    step(1'b1, 32'h64, 32'd7, 1'b0);
    step(1'b1, 32'h68, 32'd9, 1'b0);
    step(1'b0, 32'h64, 32'd0, 1'b0);
    check("fwd64_hit", 64'(obs_hit), 64'd1);
    check("fwd64_dat", 64'(obs_fdata), 64'd7);
    step(1'b0, 32'h66, 32'd0, 1'b0);
    check("fwd66_hit", 64'(obs_hit), 64'd1);
    check("fwd66_dat", 64'(obs_fdata), 64'd7);
    step(1'b0, 32'h6C, 32'd0, 1'b0);
    check("fwd6c_hit", 64'(obs_hit), 64'd0);
    check("fwd6c_dat", 64'(obs_fdata), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'd0, 1'b1);

    // Wrap-around with toggling ready
    drained.delete();
    for (int i = 0; i < 10; i++) begin
      tries = 0;
      do begin
        step(1'b1, 32'h100 + 32'(4 * i), 32'(11 * i + 1), ((i + tries) % 2) == 0);
        tries++;
      end while (obs_stall && tries < 8);
      if (obs_stall) check("wrap_retry_budget", 64'd1, 64'd0);
    end
    tries = 0;
    while (model_q.size() != 0 && tries < 20) begin
      step(1'b0, 32'h0, 32'd0, 1'b1);
      tries++;
    end
    check("wrap_n", 64'(drained.size()), 64'd10);
    for (int i = 0; i < 10 && i < drained.size(); i++)
      check("wrap_order", 64'(drained[i]), 64'(32'h100 + 32'(4 * i)));

    // Async reset with entries pending
    for (int i = 0; i < 3; i++) step(1'b1, 32'h80 + 32'(4 * i), 32'(i + 20), 1'b0);
    @(negedge clk);
    bus.MemWrite  = 1'b0;
    bus.ALUResult = 32'h80;
    #2;
    reset = 1'b0;
    #1;
    check("ar_memvalid", 64'(bus.MemValid), 64'd0);
    check("ar_count",    64'(bus.Count),    64'd0);
    check("ar_fwdhit",   64'(bus.FwdHit),   64'd0);
    model_q.delete();
    @(negedge clk);
    reset = 1'b1;
    single_store();

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      a = 32'h200 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), a, 32'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle core's data port and data memory. Each core store (MemWrite with address and write data) is captured into a small FIFO in one cycle; entries then drain to memory in order over a valid/ready handshake. The core is stalled only when the buffer is full. Loads get store-to-load forwarding, so a load returns the youngest buffered data for its word address.

## Interface
- DEPTH, 4: number of entries; power of two, at least 2.
- AW, 32: address width.
- DW, 32: data width.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- MemWrite  in  1  core store request this cycle.
- ALUResult  in  AW  store address, or load address when MemWrite=0.
- WriteData  in  DW  store data.
- Stall  out  1  combinational; MemWrite && full. The core holds its store while Stall=1.
- FwdHit  out  1  combinational; a buffered entry matches ALUResult[AW-1:2].
- FwdData  out  DW  data of the youngest matching entry; 0 when FwdHit=0.
- MemValid  out  1  head entry present (not empty).
- MemAddr  out  AW  head entry address.
- MemWData  out  DW  head entry data.
- MemReady  in  1  memory accepts the head entry this cycle.
- Empty  out  1  count==0; used by the core for fences and halt.
- Count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH entries of {addr, data, valid}; head pointer (rd_ptr) and tail pointer (wr_ptr), each $clog2(DEPTH) bits, wrapping modulo DEPTH; registered count.
- push = MemWrite && !full. The entry is written at wr_ptr, then wr_ptr increments.
- pop = MemValid && MemReady. The head entry is invalidated, then rd_ptr increments.
- full = (count==DEPTH). There is no pass-through: a push while full is refused (Stall=1), even if a pop occurs in the same cycle. The core retries the next cycle.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Pop when empty cannot occur, because MemValid=0. MemReady is ignored when empty.
- MemAddr and MemWData are taken combinationally from entry[rd_ptr]. They stay stable while MemValid && !MemReady.
- Forwarding:
  - Compare ALUResult[AW-1:2] against every valid entry.
  - Priority goes to the youngest entry (closest to wr_ptr-1, walking back with wrap).
  - The compare uses register state only. A store being pushed this cycle is not visible until the next cycle.
  - An entry being popped this cycle still forwards this cycle.
- Writes are full-word; ALUResult[1:0] is stored but not compared.
- Ordering: strict FIFO; no write merging or coalescing.

## Timing
- Reset (async assert, sync release by the core): count=0, pointers=0, all valid=0, all addr/data=0. Outputs: MemValid=0, MemAddr=0, MemWData=0, Empty=1, Count=0, FwdHit=0, FwdData=0, Stall=0.
- Reset mid-drain drops every pending entry. There is no replay.
- Enqueue-to-MemValid latency: 1 cycle. A store pushed at edge N is presented at MemValid from edge N onward, so it can pop at edge N+1 at the earliest.
- Throughput: 1 push and 1 pop per cycle.
- Stall is asserted in the same cycle as the blocked MemWrite. It deasserts in the cycle after the first pop that frees a slot.
- Count changes only on rising clk edges: +1 on push only, -1 on pop only, unchanged on both or neither.

## Test plan
- Single store: reset, hold MemReady=0, store 0x64 := 7. Next cycle: MemValid=1, MemAddr=0x64, MemWData=7, Count=1. Raise MemReady for one cycle: then Empty=1.
- Fill and stall (DEPTH=4, MemReady=0): 5 consecutive stores to 0x60, 0x64, 0x68, 0x6C, 0x70.
  - Stall=0 for the first four; Stall=1 on the fifth while Count=4.
  - One pop: Stall drops in the next cycle, the fifth store enqueues, and drain order is 0x60 through 0x70.
- Full with push and pop in the same cycle: full buffer, MemReady=1 and MemWrite=1 together. The push is refused (Stall=1), Count goes 4→3, and the store enters on the following cycle.
- Forwarding priority: store 0x64:=3, then 0x64:=7, then 0x68:=9 (MemReady=0). Load 0x64 → FwdHit=1, FwdData=7. Load 0x66 → hit, 7. Load 0x6C → FwdHit=0, FwdData=0.
- Wrap-around: 10 stores with MemReady toggling 1-0-1-0. Memory receives all 10 in order with the correct data, and the pointers wrap twice without loss.
- Async reset mid-operation: 3 entries pending, assert reset off-edge. MemValid, Count and FwdHit go to 0 immediately. After release, the first store behaves as in scenario 1.
